pixel_readback_port: RTL and testbench

Receiving end of the image engine's processed-pixel stream (proc_valid/proc_pixel).
- Packs 8-bit pixels four-per-word into a small word FIFO.
- Exposes the FIFO, status and control to the CPU through a picosoc-style iomem slave, so firmware can read back processed frames.
- Sits in the SoC next to the engine and behind the iomem address decoder. It runs on the SoC clock.

---
 rtl/readback_pkg.sv | 32 +++
 rtl/sync_word_fifo.sv | 58 +++++
 rtl/pixel_readback_port.sv | 144 ++++++++++++++
 tb/tb_pixel_readback_port.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/readback_pkg.sv
// Shared definitions for the processed-pixel readback port: register offsets, field positions, status layout.
package readback_pkg;

    localparam int unsigned LANES = 4;

    localparam logic [3:0] OFF_DATA     = 4'h0;
    localparam logic [3:0] OFF_STATUS   = 4'h4;
    localparam logic [3:0] OFF_CTRL     = 4'h8;
    localparam logic [3:0] OFF_PIXCOUNT = 4'hC;

    localparam int unsigned ST_EMPTY     = 8;
    localparam int unsigned ST_FULL      = 9;
    localparam int unsigned ST_UNDERFLOW = 10;
    localparam int unsigned ST_PARTIAL   = 11;
    localparam int unsigned ST_DROP_LSB  = 16;

    localparam int unsigned CTRL_CLEAR   = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_THR_LSB = 8;

    // STATUS register image, MSB first
    typedef struct packed {
        logic [15:0] drops;
        logic [3:0]  rsvd;
        logic        partial;
        logic        underflow;
        logic        full;
        logic        empty;
        logic [7:0]  level;
    } status_t;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock 32-bit word FIFO with occupancy level and synchronous clear.
module sync_word_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  push,
    input  logic [31:0]           push_data,
    input  logic                  pop,
    output logic [31:0]           head,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   level_nxt
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (clear) begin
            level_nxt = '0;
        end else if (push && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_nxt;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage is not reset; the pointers define validity
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pixel_readback_port.sv
// Packs the processed-pixel stream four-per-word into a FIFO and exposes it to firmware over iomem.
module pixel_readback_port
    import readback_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    input  logic        pix_last,
    output logic        pix_ready,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [3:0]  iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [1:0]       pack_cnt;
    logic [31:0]      shift_word;
    logic [31:0]      pix_count;
    logic [CNT_W-1:0] drop_cnt;
    logic             underflow;
    logic             irq_en;
    logic [7:0]       threshold;

    logic [31:0]      head_c;
    logic [31:0]      push_word_c;
    logic [31:0]      rd_mux_c;
    logic [LVL_W-1:0] level_c;
    logic [LVL_W-1:0] level_nxt_c;
    logic [3:0]       reg_off_c;
    status_t          status_c;
    logic full_c, empty_c, bus_go_c, bus_rd_c, ctrl_wr_c, clr_c;
    logic accept_c, drop_c, push_c, pop_c, underrun_c;
    logic unused_bits_c;

    assign full_c      = (level_c == LVL_W'(DEPTH));
    assign empty_c     = (level_c == '0);
    assign pix_ready   = !full_c;
    assign reg_off_c   = {iomem_addr[3:2], 2'b00};
    assign bus_go_c    = iomem_valid && !iomem_ready;
    assign bus_rd_c    = bus_go_c && (iomem_wstrb == 4'b0000);
    assign ctrl_wr_c   = bus_go_c && (iomem_wstrb != 4'b0000) && (reg_off_c == OFF_CTRL);
    assign clr_c       = ctrl_wr_c && iomem_wstrb[0] && iomem_wdata[CTRL_CLEAR];
    // A clear landing in the same cycle swallows any incoming pixel
    assign accept_c    = pix_valid && !full_c && !clr_c;
    assign drop_c      = pix_valid && full_c && !clr_c;
    assign push_c      = accept_c && (pix_last || (pack_cnt == 2'(LANES - 1)));
    assign pop_c       = bus_rd_c && (reg_off_c == OFF_DATA) && !empty_c;
    assign underrun_c  = bus_rd_c && (reg_off_c == OFF_DATA) && empty_c;
    assign push_word_c = shift_word | (32'(pix_data) << {pack_cnt, 3'b000});
    assign unused_bits_c = &{1'b0, iomem_addr[1:0], iomem_wdata[31:16], iomem_wdata[7:2]};

    sync_word_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clr_c),
        .push      (push_c),
        .push_data (push_word_c),
        .pop       (pop_c),
        .head      (head_c),
        .level     (level_c),
        .level_nxt (level_nxt_c)
    );

    always_comb begin
        status_c           = '0;
        status_c.level     = 8'(level_c);
        status_c.empty     = empty_c;
        status_c.full      = full_c;
        status_c.underflow = underflow;
        status_c.partial   = (pack_cnt != 2'd0);
        status_c.drops     = 16'(drop_cnt);
    end

    always_comb begin
        rd_mux_c = '0;
        case (reg_off_c)
            OFF_DATA:     rd_mux_c = empty_c ? 32'd0 : head_c;
            OFF_STATUS:   rd_mux_c = status_c;
            OFF_CTRL:     rd_mux_c = {16'd0, threshold, 6'd0, irq_en, 1'b0};
            OFF_PIXCOUNT: rd_mux_c = pix_count;
            default:      rd_mux_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pack_cnt    <= '0;
            shift_word  <= '0;
            pix_count   <= '0;
            drop_cnt    <= '0;
            underflow   <= 1'b0;
            irq_en      <= 1'b0;
            threshold   <= '0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            irq         <= 1'b0;
        end else begin
            iomem_ready <= bus_go_c;
            iomem_rdata <= bus_rd_c ? rd_mux_c : 32'd0;
            if (clr_c) begin
                pack_cnt   <= '0;
                shift_word <= '0;
                pix_count  <= '0;
                drop_cnt   <= '0;
                underflow  <= 1'b0;
            end else begin
                if (accept_c) begin
                    pix_count <= pix_count + 32'd1;
                    if (push_c) begin
                        pack_cnt   <= '0;
                        shift_word <= '0;
                    end else begin
                        pack_cnt   <= pack_cnt + 2'd1;
                        shift_word <= push_word_c;
                    end
                end else if (drop_c) begin
                    if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
                    if (pix_last) begin
                        pack_cnt   <= '0;
                        shift_word <= '0;
                    end
                end
                if (underrun_c) underflow <= 1'b1;
            end
            if (ctrl_wr_c) begin
                if (iomem_wstrb[0]) irq_en    <= iomem_wdata[CTRL_IRQ_EN];
                if (iomem_wstrb[1]) threshold <= iomem_wdata[CTRL_THR_LSB +: 8];
            end
            irq <= irq_en && (threshold != 8'd0) && (32'(level_nxt_c) >= 32'(threshold));
        end
    end

endmodule

// File: tb/tb_pixel_readback_port.sv
// Directed bench for pixel_readback_port: packing, flush, overflow, underflow, irq and bus corners.
module tb_pixel_readback_port;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_last;
    logic        pix_ready;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [3:0]  iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        irq;

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  rpat;

    pixel_readback_port #(
        .DEPTH_LOG2 (4),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .pix_ready   (pix_ready),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pix(input logic [7:0] d, input logic last);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    // One iomem access, bounded wait for the acknowledge
    task automatic bus(input logic [3:0] a, input logic [3:0] s, input logic [31:0] wd,
                       output logic [31:0] rd);
        int n;
        n = 0;
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = wd;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!iomem_ready && n < 8);
        chk("bus_ack", 32'(iomem_ready), 32'd1);
        rd = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(a, 4'b0000, 32'd0, r);
        chk(tag, r, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r;
        bus(a, s, d, r);
    endtask

    initial begin
        resetn      = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = 8'd0;
        pix_last    = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        iomem_addr  = 4'h0;
        iomem_wdata = 32'd0;
        idle(3);
        chk("rst_ready", 32'(iomem_ready), 32'd0);
        chk("rst_rdata", iomem_rdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
        resetn = 1'b1;
        idle(1);
        rd_chk("rst_status", 4'h4, 32'h0000_0100);
        rd_chk("rst_pixcount", 4'hC, 32'd0);

        // Pack eight pixels into two words
        for (int i = 1; i <= 8; i++) send_pix(8'(i), 1'b0);
        rd_chk("pack_status", 4'h4, 32'h0000_0002);
        rd_chk("pack_w0", 4'h0, 32'h0403_0201);
        rd_chk("pack_w1", 4'h0, 32'h0807_0605);
        rd_chk("pack_empty", 4'h4, 32'h0000_0100);

        // Partial word flushed by pix_last
        send_pix(8'hAA, 1'b0);
        send_pix(8'hBB, 1'b0);
        rd_chk("partial_pending", 4'h4, 32'h0000_0900);
        send_pix(8'hCC, 1'b1);
        rd_chk("partial_word", 4'h0, 32'h00CC_BBAA);
        rd_chk("partial_done", 4'h4, 32'h0000_0100);
        rd_chk("pixcount_11", 4'hC, 32'd11);

        // Underflow on empty DATA read
        rd_chk("under_rdata", 4'h0, 32'd0);
        idle(1);
        chk("under_ready_pulse", 32'(iomem_ready), 32'd0);
        rd_chk("under_status", 4'h4, 32'h0000_0500);

        // Held valid: acknowledge must alternate
        idle(1);
        iomem_valid = 1'b1;
        iomem_addr  = 4'h4;
        iomem_wstrb = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            rpat[i] = iomem_ready;
        end
        iomem_valid = 1'b0;
        chk("ready_alternates", 32'(rpat), 32'h0000_0005);

        // Clear
        wr(4'h8, 4'b0001, 32'h0000_0001);
        rd_chk("clr_status", 4'h4, 32'h0000_0100);
        rd_chk("clr_pixcount", 4'hC, 32'd0);

        // Overflow: 64 accepted, 5 dropped
        for (int i = 0; i < 64; i++) send_pix(8'(i), 1'b0);
        chk("ovf_pix_ready", 32'(pix_ready), 32'd0);
        for (int i = 0; i < 5; i++) send_pix(8'hEE, 1'b0);
        rd_chk("ovf_status", 4'h4, 32'h0005_0210);
        rd_chk("ovf_pixcount", 4'hC, 32'd64);
        rd_chk("ovf_pop", 4'h0, 32'h0302_0100);
        chk("ovf_room", 32'(pix_ready), 32'd1);
        rd_chk("ovf_level15", 4'h4, 32'h0005_000F);
        wr(4'h8, 4'b0001, 32'h0000_0001);

        // Interrupt at threshold 4
        wr(4'h8, 4'b0011, 32'h0000_0402);
        rd_chk("ctrl_read", 4'h8, 32'h0000_0402);
        for (int i = 0; i < 12; i++) send_pix(8'(i), 1'b0);
        idle(2);
        chk("irq_below", 32'(irq), 32'd0);
        for (int i = 12; i < 16; i++) send_pix(8'(i), 1'b0);
        idle(2);
        chk("irq_set", 32'(irq), 32'd1);
        rd_chk("irq_pop", 4'h0, 32'h0302_0100);
        idle(2);
        chk("irq_clear", 32'(irq), 32'd0);
        wr(4'h8, 4'b0001, 32'h0000_0003);
        rd_chk("ctrl_kept", 4'h8, 32'h0000_0402);
        wr(4'h8, 4'b0011, 32'h0000_0000);

        // Push and pop in the same cycle at level 2
        for (int i = 0; i < 11; i++) send_pix(8'(8'h10 + i), 1'b0);
        rd_chk("pp_level", 4'h4, 32'h0000_0802);
        idle(1);
        iomem_valid = 1'b1;
        iomem_addr  = 4'h0;
        iomem_wstrb = 4'b0000;
        pix_valid   = 1'b1;
        pix_data    = 8'h1B;
        @(posedge clk);
        #1;
        pix_valid   = 1'b0;
        iomem_valid = 1'b0;
        chk("pp_ack", 32'(iomem_ready), 32'd1);
        chk("pp_rdata", iomem_rdata, 32'h1312_1110);
        rd_chk("pp_status", 4'h4, 32'h0000_0002);
        rd_chk("pp_w1", 4'h0, 32'h1716_1514);
        rd_chk("pp_w2", 4'h0, 32'h1B1A_1918);
        rd_chk("pp_empty", 4'h4, 32'h0000_0100);

        // Clear coinciding with an incoming pixel
        for (int i = 0; i < 4; i++) send_pix(8'(8'h20 + i), 1'b0);
        idle(1);
        iomem_valid = 1'b1;
        iomem_addr  = 4'h8;
        iomem_wstrb = 4'b0001;
        iomem_wdata = 32'h0000_0001;
        pix_valid   = 1'b1;
        pix_data    = 8'h55;
        @(posedge clk);
        #1;
        pix_valid   = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        chk("clrpx_ack", 32'(iomem_ready), 32'd1);
        rd_chk("clrpx_status", 4'h4, 32'h0000_0100);
        rd_chk("clrpx_count", 4'hC, 32'd0);

        // Reset during a pending access
        for (int i = 0; i < 4; i++) send_pix(8'(8'h30 + i), 1'b0);
        idle(1);
        iomem_valid = 1'b1;
        iomem_addr  = 4'h0;
        iomem_wstrb = 4'b0000;
        resetn      = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid_ready", 32'(iomem_ready), 32'd0);
        chk("rstmid_rdata", iomem_rdata, 32'd0);
        resetn      = 1'b1;
        iomem_valid = 1'b0;
        idle(1);
        rd_chk("rstmid_status", 4'h4, 32'h0000_0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
